// File: rtl/rf_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rf_ctrl_pkg                                                           |
// | Op and FSM state encodings shared by the register-access controller.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package rf_ctrl_pkg;

    typedef logic [1:0] op_t;
    typedef logic [2:0] state_t;

    localparam op_t C_OP_READ  = 2'b00;
    localparam op_t C_OP_WRITE = 2'b01;
    localparam op_t C_OP_MOVE  = 2'b10;
    localparam op_t C_OP_SWAP  = 2'b11;

    localparam state_t C_ST_IDLE = 3'd0;
    localparam state_t C_ST_PRE  = 3'd1;
    localparam state_t C_ST_RD   = 3'd2;
    localparam state_t C_ST_CAP  = 3'd3;
    localparam state_t C_ST_WR1  = 3'd4;
    localparam state_t C_ST_WR2  = 3'd5;
    localparam state_t C_ST_DONE = 3'd6;

endpackage : rf_ctrl_pkg
`default_nettype wire

// File: rtl/reg_access_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | reg_access_ctrl_if                                                    |
// | Command/response bundle between a command source and the controller. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface reg_access_ctrl_if
    import rf_ctrl_pkg::*;
#(
    parameter int AW = 2,
    parameter int DW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    op_t           cmd_op;
    logic [AW-1:0] cmd_a;
    logic [AW-1:0] cmd_b;
    logic [DW-1:0] cmd_imm;
    logic          done;
    logic [DW-1:0] result;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_imm,
        input  cmd_ready, done, result
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_imm,
        output cmd_ready, done, result
    );

endinterface : reg_access_ctrl_if
`default_nettype wire

// File: rtl/rf_wport_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rf_wport_reg                                                          |
// | Falling-edge register-file write port; outputs only move while clk is |
// | low so the register file can gate its clock with the write enable.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module rf_wport_reg #(
    parameter int AW = 2,
    parameter int DW = 32
) (
    input  wire           clk,
    input  wire           reset,
    input  wire           we_d,
    input  wire  [AW-1:0] wreg_d,
    input  wire  [DW-1:0] wdata_d,
    output logic          rf_we,
    output logic [AW-1:0] rf_wreg,
    output logic [DW-1:0] rf_wdata
);

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            rf_we    <= 1'b0;
            rf_wreg  <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= we_d;
            // Address/data hold their last value between writes.
            if (we_d) begin
                rf_wreg  <= wreg_d;
                rf_wdata <= wdata_d;
            end
        end
    end

endmodule : rf_wport_reg
`default_nettype wire

// File: rtl/reg_access_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | reg_access_ctrl                                                       |
// | Sequences READ/WRITE/MOVE/SWAP commands onto a 2R1W register file.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module reg_access_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int AW = 2,
    parameter int DW = 32
) (
    input  wire              clk,
    input  wire              reset,
    reg_access_ctrl_if.slave cmd,
    output logic [AW-1:0]    rf_rreg1,
    output logic [AW-1:0]    rf_rreg2,
    input  wire  [DW-1:0]    rf_rdata1,
    input  wire  [DW-1:0]    rf_rdata2,
    output logic [AW-1:0]    rf_wreg,
    output logic [DW-1:0]    rf_wdata,
    output logic             rf_we
);

    state_t        r_state;
    op_t           r_op;
    logic [AW-1:0] r_a;
    logic [AW-1:0] r_b;
    logic [DW-1:0] r_imm;
    logic [DW-1:0] r_t1;
    logic [DW-1:0] r_t2;
    logic          r_done;
    logic [DW-1:0] r_result;

    logic          w_we;
    logic [AW-1:0] w_wreg;
    logic [DW-1:0] w_wdata;

    assign cmd.cmd_ready = (r_state == C_ST_IDLE);
    assign cmd.done      = r_done;
    assign cmd.result    = r_result;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= C_ST_IDLE;
            r_op     <= C_OP_READ;
            r_a      <= '0;
            r_b      <= '0;
            r_imm    <= '0;
            r_t1     <= '0;
            r_t2     <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
            rf_rreg1 <= '0;
            rf_rreg2 <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                C_ST_IDLE: begin
                    if (cmd.cmd_valid) begin
                        r_op  <= cmd.cmd_op;
                        r_a   <= cmd.cmd_a;
                        r_b   <= cmd.cmd_b;
                        r_imm <= cmd.cmd_imm;
                        if (cmd.cmd_op == C_OP_WRITE) begin
                            r_state <= C_ST_WR1;
                        end else begin
                            // Inverted selects first so the read mux always sees a change.
                            r_state  <= C_ST_PRE;
                            rf_rreg1 <= ~cmd.cmd_a;
                            rf_rreg2 <= ~cmd.cmd_b;
                        end
                    end
                end
                C_ST_PRE: begin
                    r_state  <= C_ST_RD;
                    rf_rreg1 <= r_a;
                    rf_rreg2 <= r_b;
                end
                C_ST_RD: begin
                    r_state <= C_ST_CAP;
                end
                C_ST_CAP: begin
                    r_t1    <= rf_rdata1;
                    r_t2    <= rf_rdata2;
                    r_state <= (r_op == C_OP_READ) ? C_ST_DONE : C_ST_WR1;
                end
                C_ST_WR1: begin
                    r_state <= (r_op == C_OP_SWAP) ? C_ST_WR2 : C_ST_DONE;
                end
                C_ST_WR2: begin
                    r_state <= C_ST_DONE;
                end
                C_ST_DONE: begin
                    r_state  <= C_ST_IDLE;
                    r_done   <= 1'b1;
                    r_result <= (r_op == C_OP_WRITE) ? r_imm : r_t1;
                end
                default: begin
                    r_state <= C_ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_we    = 1'b0;
        w_wreg  = r_a;
        w_wdata = r_t1;
        case (r_state)
            C_ST_WR1: begin
                w_we = 1'b1;
                case (r_op)
                    C_OP_WRITE: w_wdata = r_imm;
                    C_OP_MOVE:  w_wreg  = r_b;
                    default:    w_wdata = r_t2;
                endcase
            end
            C_ST_WR2: begin
                w_we   = 1'b1;
                w_wreg = r_b;
            end
            default: ;
        endcase
    end

    rf_wport_reg #(
        .AW (AW),
        .DW (DW)
    ) u_wport (
        .clk      (clk),
        .reset    (reset),
        .we_d     (w_we),
        .wreg_d   (w_wreg),
        .wdata_d  (w_wdata),
        .rf_we    (rf_we),
        .rf_wreg  (rf_wreg),
        .rf_wdata (rf_wdata)
    );

endmodule : reg_access_ctrl
`default_nettype wire

// File: tb/tb_reg_access_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_reg_access_ctrl                                                    |
// | Random and directed commands against a command-level reference model. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_reg_access_ctrl;

    localparam int AW = 2;
    localparam int DW = 32;
    localparam logic [1:0] OP_RD = 2'b00;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_MV = 2'b10;
    localparam logic [1:0] OP_SW = 2'b11;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    reg_access_ctrl_if #(.AW(AW), .DW(DW)) cmd_if ();

    logic [AW-1:0] rf_rreg1, rf_rreg2, rf_wreg;
    logic [DW-1:0] rf_rdata1, rf_rdata2, rf_wdata;
    logic          rf_we;

    reg_access_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd       (cmd_if),
        .rf_rreg1  (rf_rreg1),
        .rf_rreg2  (rf_rreg2),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .rf_wreg   (rf_wreg),
        .rf_wdata  (rf_wdata),
        .rf_we     (rf_we)
    );

    // Register file the controller drives: async read, clock gated by write enable.
    logic [DW-1:0] rf_mem [4] = '{default: '0};
    assign rf_rdata1 = rf_mem[rf_rreg1];
    assign rf_rdata2 = rf_mem[rf_rreg2];
    always @(posedge clk) if (rf_we) rf_mem[rf_wreg] <= rf_wdata;

    typedef struct {
        int            cyc;
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           wq[$];
    logic [DW-1:0] m  [4] = '{default: '0};
    logic [DW-1:0] nx [4] = '{default: '0};
    int            cyc = 0, n_cmp = 0, n_bad = 0;
    int            acc_count = 0, acc_cyc = 0, done_cyc = 0, nwr = 0;
    bit            have = 1'b0;
    logic [DW-1:0] res_now = '0, res_prev = '0;
    logic [1:0]    cur_op = '0;
    logic [AW-1:0] cur_a = '0, cur_b = '0;

    function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: actual %h required %h", name, cyc, act, exp);
        end
    endfunction

    // Command-level model: what each accepted command must do and when.
    task automatic model_edge();
        wr_t w;
        logic [AW-1:0] a, b;
        logic [DW-1:0] imm;
        cyc++;
        if (!reset) begin
            have = 1'b0; wq.delete(); res_now = '0; res_prev = '0;
        end else begin
            chk("rf_we_at_posedge", DW'(rf_we), DW'(wq.size() > 0 && wq[0].cyc == cyc));
            if (rf_we) begin
                nwr++;
                if (wq.size() > 0 && wq[0].cyc == cyc) begin
                    w = wq.pop_front();
                    chk("rf_wreg", DW'(rf_wreg), DW'(w.r));
                    chk("rf_wdata", rf_wdata, w.d);
                end
            end
            if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
                a = cmd_if.cmd_a; b = cmd_if.cmd_b; imm = cmd_if.cmd_imm;
                if (have) res_prev = res_now;
                have = 1'b1; acc_count++; acc_cyc = cyc; nwr = 0;
                cur_op = cmd_if.cmd_op; cur_a = a; cur_b = b;
                foreach (m[i]) nx[i] = m[i];
                res_now = m[a];
                case (cmd_if.cmd_op)
                    OP_RD: done_cyc = cyc + 4;
                    OP_WR: begin
                        res_now = imm; nx[a] = imm; done_cyc = cyc + 2;
                        w = '{cyc + 1, a, imm}; wq.push_back(w);
                    end
                    OP_MV: begin
                        nx[b] = m[a]; done_cyc = cyc + 5;
                        w = '{cyc + 4, b, m[a]}; wq.push_back(w);
                    end
                    default: begin
                        nx[a] = m[b]; nx[b] = m[a]; done_cyc = cyc + 6;
                        w = '{cyc + 4, a, m[b]}; wq.push_back(w);
                        w = '{cyc + 5, b, m[a]}; wq.push_back(w);
                    end
                endcase
            end
        end
    endtask

    task automatic check_cycle();
        bit fin;
        logic [AW-1:0] na, nb;
        if (!reset) return;
        fin = have && cyc >= done_cyc;
        chk("cmd_ready", DW'(cmd_if.cmd_ready), DW'(!have || fin));
        chk("done", DW'(cmd_if.done), DW'(have && cyc == done_cyc));
        chk("result", cmd_if.result, fin ? res_now : res_prev);
        if (have && cur_op != OP_WR && cyc == acc_cyc) begin
            na = ~cur_a; nb = ~cur_b;
            chk("rreg1_pre", DW'(rf_rreg1), DW'(na));
            chk("rreg2_pre", DW'(rf_rreg2), DW'(nb));
        end
        if (have && cur_op != OP_WR && (cyc == acc_cyc + 1 || cyc == acc_cyc + 2)) begin
            chk("rreg1_rd", DW'(rf_rreg1), DW'(cur_a));
            chk("rreg2_rd", DW'(rf_rreg2), DW'(cur_b));
        end
        if (have && cyc == done_cyc) begin
            chk("writes_outstanding", DW'(wq.size()), 0);
            foreach (m[i]) begin
                chk($sformatf("regfile[%0d]", i), rf_mem[i], nx[i]);
                m[i] = nx[i];
            end
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [DW-1:0] imm);
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = op;
        cmd_if.cmd_a = a; cmd_if.cmd_b = b; cmd_if.cmd_imm = imm;
    endtask

    task automatic wait_accept(input int base);
        int t = 0;
        while (acc_count == base && t < 40) begin @(posedge clk); #1; t++; end
        chk("accept_seen", DW'(acc_count - base), 1);
    endtask

    task automatic wait_done(output int lat);
        int t = 0;
        while (cmd_if.done !== 1'b1 && t < 40) begin @(negedge clk); #1; t++; end
        chk("done_seen", DW'(cmd_if.done), 1);
        lat = cyc - acc_cyc;
    endtask

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [DW-1:0] imm, output int lat);
        int base;
        @(negedge clk); #1;
        base = acc_count;
        drive(op, a, b, imm);
        wait_accept(base);
        cmd_if.cmd_valid = 1'b0;
        wait_done(lat);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_done"}, DW'(cmd_if.done), 0);
        chk({tag, "_result"}, cmd_if.result, 0);
        chk({tag, "_rf_we"}, DW'(rf_we), 0);
        chk({tag, "_rf_wreg"}, DW'(rf_wreg), 0);
        chk({tag, "_rf_wdata"}, rf_wdata, 0);
        chk({tag, "_rf_rreg1"}, DW'(rf_rreg1), 0);
        chk({tag, "_rf_rreg2"}, DW'(rf_rreg2), 0);
    endtask

    task automatic run_stimulus();
        int lat, base, first_acc;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = OP_RD;
        cmd_if.cmd_a = '0; cmd_if.cmd_b = '0; cmd_if.cmd_imm = '0;
        repeat (2) @(negedge clk); #1;
        check_all_zero("reset");
        reset = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", DW'(cmd_if.cmd_ready), 1);

        issue(OP_WR, 2'd3, 2'd0, 32'hA5A5_A5A5, lat);
        chk("write_latency", DW'(lat), 2);
        chk("write_result", cmd_if.result, 32'hA5A5_A5A5);
        chk("write_count", DW'(nwr), 1);
        chk("write_reg3", rf_mem[3], 32'hA5A5_A5A5);

        repeat (2) begin
            issue(OP_RD, 2'd3, 2'd2, 32'h0, lat);
            chk("read_latency", DW'(lat), 4);
            chk("read_result", cmd_if.result, 32'hA5A5_A5A5);
        end

        issue(OP_WR, 2'd0, 2'd0, 32'd1, lat);
        issue(OP_WR, 2'd1, 2'd0, 32'd2, lat);
        issue(OP_SW, 2'd0, 2'd1, 32'h0, lat);
        chk("swap_latency", DW'(lat), 6);
        chk("swap_result", cmd_if.result, 32'd1);
        chk("swap_count", DW'(nwr), 2);
        chk("swap_reg0", rf_mem[0], 32'd2);
        chk("swap_reg1", rf_mem[1], 32'd1);

        issue(OP_WR, 2'd2, 2'd0, 32'hFFFF_FFFF, lat);
        issue(OP_MV, 2'd2, 2'd0, 32'h0, lat);
        chk("move_latency", DW'(lat), 5);
        chk("move_count", DW'(nwr), 1);
        chk("move_reg0", rf_mem[0], 32'hFFFF_FFFF);
        chk("move_reg2", rf_mem[2], 32'hFFFF_FFFF);

        issue(OP_WR, 2'd1, 2'd0, 32'h1234_5678, lat);
        issue(OP_SW, 2'd1, 2'd1, 32'h0, lat);
        chk("swap_same_count", DW'(nwr), 2);
        chk("swap_same_reg1", rf_mem[1], 32'h1234_5678);

        // Reset lands just after the write enable rises inside WR1 of a SWAP.
        @(negedge clk); #1;
        base = acc_count;
        drive(OP_SW, 2'd0, 2'd1, 32'h0);
        wait_accept(base);
        cmd_if.cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("we_in_wr1", DW'(rf_we), 1);
        reset = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (2) @(negedge clk); #1;
        reset = 1'b1;
        chk("abort_reg0", rf_mem[0], 32'hFFFF_FFFF);
        chk("abort_reg1", rf_mem[1], 32'h1234_5678);
        @(posedge clk); #1;
        chk("ready_after_abort", DW'(cmd_if.cmd_ready), 1);

        // cmd_valid held across a busy command: the next one waits for done.
        @(negedge clk); #1;
        base = acc_count;
        drive(OP_RD, 2'd3, 2'd0, 32'h0);
        wait_accept(base);
        first_acc = acc_cyc;
        drive(OP_WR, 2'd1, 2'd0, 32'hCAFE_F00D);
        wait_accept(base + 1);
        chk("hold_accept_gap", DW'(acc_cyc - first_acc), 5);
        cmd_if.cmd_valid = 1'b0;
        wait_done(lat);
        chk("hold_write_latency", DW'(lat), 2);
        chk("hold_reg1", rf_mem[1], 32'hCAFE_F00D);

        for (int n = 0; n < 60; n++) begin
            issue(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  $urandom, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        fork
            forever begin @(posedge clk); model_edge(); end
            forever begin @(negedge clk); check_cycle(); end
            forever begin @(rf_we); chk("rf_we_edge_clk_level", DW'(clk), 0); end
            run_stimulus();
        join_any
        disable fork;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_reg_access_ctrl
`default_nettype wire

// File: doc/reg_access_ctrl.md
REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

Interface
REQ-001 SHALL have parameter AW, default 2, meaning register-address width (4 registers).
REQ-002 SHALL have parameter DW, default 32, meaning data width.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  controller idle and accepting.
REQ-007 SHALL have port cmd_op  input  2  00 READ, 01 WRITE, 10 MOVE, 11 SWAP.
REQ-008 SHALL have ports cmd_a, cmd_b  input  AW  operand register numbers.
REQ-009 SHALL have port cmd_imm  input  DW  WRITE data.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port result  output  DW  command result.
REQ-012 SHALL have ports rf_rreg1, rf_rreg2  output  AW  register-file read selects.
REQ-013 SHALL have ports rf_rdata1, rf_rdata2  input  DW  register-file read data.
REQ-014 SHALL have ports rf_wreg, rf_wdata, rf_we  output  AW/DW/1  register-file write port.

Function
REQ-015 SHALL use FSM states IDLE, PRE, RD, CAP, WR1, WR2, DONE.
REQ-016 SHALL assert cmd_ready only in IDLE.
REQ-017 SHALL latch the op, a, b and imm at the accepting posedge (cmd_valid & cmd_ready).
REQ-018 SHALL ignore cmd_valid outside IDLE.
REQ-019 SHALL go IDLE->WR1 for WRITE and IDLE->PRE for every other op.
REQ-020 SHALL drive rf_rreg1=~a and rf_rreg2=~b in PRE, then a and b in RD and CAP, so every read sees a select change.
REQ-021 SHALL capture rf_rdata1 into t1 and rf_rdata2 into t2 at the posedge ending CAP.
REQ-022 SHALL sequence states after CAP: READ to DONE; MOVE to WR1 then DONE; SWAP to WR1, WR2, DONE.
REQ-023 SHALL write in WR1: WRITE a<=imm; MOVE b<=t1; SWAP a<=t2.
REQ-024 SHALL write b<=t1 in WR2 (SWAP only).
REQ-025 SHALL launch rf_we, rf_wreg and rf_wdata from negedge-clk flops, so they are stable while clk is high, because the register file gates its clock with the write enable.
REQ-026 SHALL commit each write at the posedge ending its WR state; rf_we is high only from the negedge inside WR1/WR2 to the following negedge.
REQ-027 SHALL raise done k posedges after the accepting posedge: WRITE 2, READ 4, MOVE 5, SWAP 6; done lasts one cycle, then the FSM returns to IDLE.
REQ-028 SHALL set result to imm for WRITE and t1 (old a) for READ/MOVE/SWAP; result holds until the next done.
REQ-029 SHALL perform both writes for SWAP and MOVE with a==b, leaving the register value unchanged.
REQ-030 SHALL leave rf_rreg1, rf_rreg2 at their last value in IDLE.

Reset
REQ-031 SHALL, on reset low, immediately force state IDLE; done, rf_we, result, t1, t2, rf_wreg, rf_wdata, rf_rreg1 and rf_rreg2 go to 0.
REQ-032 SHALL abort any command in progress when reset asserts mid-operation, with no further writes.
REQ-033 SHALL assert cmd_ready from the first posedge after reset deasserts.

Structure
REQ-034 SHALL place op encodings and FSM state encodings in shared package rf_ctrl_pkg.
REQ-035 SHALL implement the negedge write-port stage as sub-module rf_wport_reg.

Verification
REQ-036 SHALL check: after reset, WRITE a=3 imm=A5A5A5A5 -> one rf_we pulse with wreg=3, done 2 cycles after accept, result=A5A5A5A5.
REQ-037 SHALL check: READ a=3 after the previous step -> done at +4, result=A5A5A5A5, including when rf_rreg1 was already 3.
REQ-038 SHALL check: regs 0=1, 1=2, then SWAP a=0 b=1 -> reg0=2, reg1=1, result=1, exactly two rf_we pulses, done at +6.
REQ-039 SHALL check: MOVE a=2 (FFFFFFFF) b=0 -> reg0=FFFFFFFF, reg2 unchanged, done at +5.
REQ-040 SHALL check: reset pulsed during SWAP WR1 -> no WR2 write, all outputs 0, cmd_ready=1 after release.
REQ-041 SHALL check: cmd_valid held high during a busy command -> the second command is accepted only after done, and no rf_we transition ever occurs while clk is high.
